// File: rtl/clk_gate_pkg.sv
// ----------------------------------------------------------------------------
// clk_gate_pkg
// Shared types and constants for the per-domain clock/operand gate-enable
// controller (clk_gate_en_ctrl) and its channel sub-module (clk_gate_chan).
//
// Contents:
//   gate_state_e : per-channel state (ST_ON, ST_OFF, ST_WAKE), 2-bit encoded
//   STATS_W      : width of each per-channel OFF-cycle statistics counter,
//                  used only when CLK_GATE_STATS_EN is defined
// ----------------------------------------------------------------------------
package clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_OFF  = 2'd1,
        ST_WAKE = 2'd2
    } gate_state_e;

    localparam int STATS_W = 32;

endpackage : clk_gate_pkg

// File: rtl/clk_gate_chan.sv
// ----------------------------------------------------------------------------
// clk_gate_chan
// One gated domain: ON/OFF/WAKE state machine with a shared idle/wake counter.
// The enable drops after idle_thr consecutive idle samples and comes back
// WAKE_CYCLES+1 edges after activity (or force_on) is seen while OFF.
//
// Optional feature macro: CLK_GATE_STATS_EN
//   When defined, adds a saturating count of cycles spent in OFF
//   (off_cycles) and a synchronous clear (stats_clr, clear wins).
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (returns to ON, en=1)
//   act        in   activity for this domain
//   force_on   in   bring the domain up and keep it up
//   idle_thr   in   idle threshold; 0 disables gating
//   en         out  registered enable to the AND2 gate (1 = pass)
//   off        out  registered, 1 while in OFF
//   in_wake    out  registered, 1 while in WAKE
//   stats_clr  in   (CLK_GATE_STATS_EN) clear the OFF-cycle counter
//   off_cycles out  (CLK_GATE_STATS_EN) saturating OFF-cycle counter
// ----------------------------------------------------------------------------
module clk_gate_chan
    import clk_gate_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               act,
    input  logic               force_on,
    input  logic [CNT_W-1:0]   idle_thr,
    output logic               en,
    output logic               off,
    output logic               in_wake
`ifdef CLK_GATE_STATS_EN
    ,
    input  logic               stats_clr,
    output logic [STATS_W-1:0] off_cycles
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    gate_state_e      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             en_reg;
    logic             off_reg;
    logic             wake_reg;

    logic [CNT_W-1:0] thr_m1;
    logic             wake_req;
    logic             gate_hit;

    assign thr_m1   = idle_thr - CNT_W'(1);
    assign wake_req = act | force_on;
    // ">=" rather than "==" so that lowering the threshold below the current
    // idle count still gates on the next idle edge instead of waiting for a
    // counter wrap that never happens (the counter saturates).
    assign gate_hit = (idle_thr != '0) && (cnt_reg >= thr_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_ON;
            cnt_reg   <= '0;
            en_reg    <= 1'b1;
            off_reg   <= 1'b0;
            wake_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_ON: begin
                    // act (or force_on) on the would-be gating edge wins.
                    if (wake_req) begin
                        cnt_reg <= '0;
                    end else if (gate_hit) begin
                        state_reg <= ST_OFF;
                        cnt_reg   <= '0;
                        en_reg    <= 1'b0;
                        off_reg   <= 1'b1;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_OFF: begin
                    if (wake_req) begin
                        state_reg <= ST_WAKE;
                        cnt_reg   <= '0;
                        off_reg   <= 1'b0;
                        wake_reg  <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    // Inputs are ignored here: a wake-up always runs to completion.
                    if (cnt_reg == WAKE_LAST) begin
                        state_reg <= ST_ON;
                        cnt_reg   <= '0;
                        en_reg    <= 1'b1;
                        wake_reg  <= 1'b0;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_ON;
                    cnt_reg   <= '0;
                    en_reg    <= 1'b1;
                    off_reg   <= 1'b0;
                    wake_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign en      = en_reg;
    assign off     = off_reg;
    assign in_wake = wake_reg;

`ifdef CLK_GATE_STATS_EN
    logic [STATS_W-1:0] off_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_cnt_reg <= '0;
        end else if (stats_clr) begin
            off_cnt_reg <= '0;
        end else if ((state_reg == ST_OFF) && (off_cnt_reg != '1)) begin
            off_cnt_reg <= off_cnt_reg + STATS_W'(1);
        end
    end

    assign off_cycles = off_cnt_reg;
`endif

endmodule : clk_gate_chan

// File: rtl/clk_gate_en_ctrl.sv
// ----------------------------------------------------------------------------
// clk_gate_en_ctrl
// Per-domain gate-enable controller driving the in2 operand of a WIDTH-bit
// AND2 gate array (en_out[i] -> in2[i]; in1[i] carries the domain clock/data).
// Holds the programmable idle threshold, runs the config handshake and
// instantiates one clk_gate_chan per domain.
//
// Optional feature macro: CLK_GATE_STATS_EN
//   When defined, adds stats_clr input and off_cycles output (one saturating
//   32-bit OFF-cycle counter per channel, channel i at [32*i +: 32]).
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   act         in   per-domain activity [WIDTH]
//   force_on    in   global request to bring all domains up and hold them up
//   cfg_valid   in   idle-threshold write request
//   cfg_idle    in   new idle threshold [CNT_W]
//   cfg_ready   out  write accepted when cfg_valid && cfg_ready
//   en_out      out  registered enables to the AND2 array [WIDTH]
//   off_status  out  1 while the domain is in OFF [WIDTH]
// ----------------------------------------------------------------------------
module clk_gate_en_ctrl
    import clk_gate_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int CNT_W        = 8,
    parameter int IDLE_DEFAULT = 16,
    parameter int WAKE_CYCLES  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         act,
    input  logic                     force_on,
    input  logic                     cfg_valid,
    input  logic [CNT_W-1:0]         cfg_idle,
    output logic                     cfg_ready,
    output logic [WIDTH-1:0]         en_out,
    output logic [WIDTH-1:0]         off_status
`ifdef CLK_GATE_STATS_EN
    ,
    input  logic                     stats_clr,
    output logic [WIDTH*STATS_W-1:0] off_cycles
`endif
);

    logic [CNT_W-1:0] idle_thr_reg;
    logic [WIDTH-1:0] in_wake;

    // The threshold is not written while any channel is waking, so a
    // wake-up in flight never sees its surroundings change under it.
    // in_wake is registered and resets asynchronously, so cfg_ready is 1
    // as soon as reset asserts.
    assign cfg_ready = ~|in_wake;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_thr_reg <= CNT_W'(IDLE_DEFAULT);
        end else if (cfg_valid && cfg_ready) begin
            idle_thr_reg <= cfg_idle;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            clk_gate_chan #(
                .CNT_W       (CNT_W),
                .WAKE_CYCLES (WAKE_CYCLES)
            ) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .act        (act[gi]),
                .force_on   (force_on),
                .idle_thr   (idle_thr_reg),
                .en         (en_out[gi]),
                .off        (off_status[gi]),
                .in_wake    (in_wake[gi])
`ifdef CLK_GATE_STATS_EN
                ,
                .stats_clr  (stats_clr),
                .off_cycles (off_cycles[gi*STATS_W +: STATS_W])
`endif
            );
        end
    endgenerate

endmodule : clk_gate_en_ctrl
